// File: rtl/pll_clk_sequencer.sv
// Start-up and supervision sequencer for the PLL gated clock outputs: PLL reset, lock
// qualification, staggered clock enables with trailing per-domain resets, and bounded relock retries.
module pll_clk_sequencer #(
    parameter int N_CLK              = 5,
    parameter int PWD_CYCLES         = 64,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STEP_CYCLES        = 16,
    parameter int RELOCK_RETRIES     = 3,
    localparam int RW                = $clog2(RELOCK_RETRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic [N_CLK-1:0] req_en,
    output logic             pll_reset,
    output logic [N_CLK-1:0] enclk,
    output logic [N_CLK-1:0] rst_out,
    output logic             ready,
    output logic             fault,
    output logic [RW-1:0]    retry_cnt
);
    localparam int M1 = (PWD_CYCLES > LOCK_TIMEOUT) ? PWD_CYCLES : LOCK_TIMEOUT;
    localparam int M2 = (LOCK_STABLE_CYCLES > STEP_CYCLES) ? LOCK_STABLE_CYCLES : STEP_CYCLES;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW = $clog2(CMAX + 1);
    localparam int SW = $clog2(N_CLK + 1);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, SEQ_UP, RUN, FAULT} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    pcnt_reg;
    logic [SW-1:0]    step_reg;
    logic [N_CLK-1:0] pend_reg;
    logic             lock_meta_reg;
    logic             lock_s_reg;
    logic             pll_reset_reg;
    logic [N_CLK-1:0] enclk_reg;
    logic [N_CLK-1:0] rst_out_reg;
    logic             ready_reg;
    logic             fault_reg;
    logic [RW-1:0]    retry_reg;

    logic [N_CLK-1:0] rise;
    logic [N_CLK-1:0] fall;
    logic [N_CLK-1:0] pend_next;
    logic [N_CLK-1:0] step_hot;
    logic [N_CLK-1:0] prev_hot;
    logic [RW-1:0]    retry_next;
    logic             attempt_fail;

    // In RUN the enable register already mirrors the last accepted request, so it doubles
    // as the edge-detect reference for req_en.
    for (genvar gi = 0; gi < N_CLK; gi++) begin : g_chan
        assign rise[gi]      = req_en[gi] & ~enclk_reg[gi];
        assign fall[gi]      = ~req_en[gi] & enclk_reg[gi];
        assign pend_next[gi] = (pend_reg[gi] & ~fall[gi]) | rise[gi];
        assign step_hot[gi]  = (step_reg == SW'(gi));
        assign prev_hot[gi]  = (step_reg == SW'(gi + 1));
    end

    assign retry_next = (retry_reg == RW'(RELOCK_RETRIES)) ? retry_reg : retry_reg + RW'(1);

    // Lock wins over timeout; lock loss wins over any step or request change.
    assign attempt_fail = ((state_reg == WAIT_LOCK) && !lock_s_reg && (cnt_reg == CW'(LOCK_TIMEOUT - 1)))
                       || (((state_reg == SEQ_UP) || (state_reg == RUN)) && !lock_s_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RESET_PLL;
            cnt_reg       <= '0;
            pcnt_reg      <= '0;
            step_reg      <= '0;
            pend_reg      <= '0;
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
            pll_reset_reg <= 1'b1;
            enclk_reg     <= '0;
            rst_out_reg   <= '1;
            ready_reg     <= 1'b0;
            fault_reg     <= 1'b0;
            retry_reg     <= '0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s_reg    <= lock_meta_reg;
            if (attempt_fail) begin
                enclk_reg     <= '0;
                rst_out_reg   <= '1;
                ready_reg     <= 1'b0;
                pend_reg      <= '0;
                cnt_reg       <= '0;
                step_reg      <= '0;
                pll_reset_reg <= 1'b1;
                retry_reg     <= retry_next;
                if (retry_next == RW'(RELOCK_RETRIES)) begin
                    state_reg <= FAULT;
                    fault_reg <= 1'b1;
                end else begin
                    state_reg <= RESET_PLL;
                end
            end else begin
                case (state_reg)
                    RESET_PLL: begin
                        if (cnt_reg == CW'(PWD_CYCLES - 1)) begin
                            cnt_reg       <= '0;
                            pll_reset_reg <= 1'b0;
                            state_reg     <= WAIT_LOCK;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s_reg) begin
                            cnt_reg   <= '0;
                            state_reg <= STABLE;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    STABLE: begin
                        if (!lock_s_reg) begin
                            cnt_reg   <= '0;
                            state_reg <= WAIT_LOCK;
                        end else if (cnt_reg == CW'(LOCK_STABLE_CYCLES - 1)) begin
                            cnt_reg   <= '0;
                            step_reg  <= '0;
                            state_reg <= SEQ_UP;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    SEQ_UP: begin
                        // Step k gates channel k and releases channel k-1 from what it latched.
                        if (cnt_reg == '0) begin
                            enclk_reg   <= (enclk_reg & ~step_hot) | (req_en & step_hot);
                            rst_out_reg <= (rst_out_reg & ~prev_hot) | (~enclk_reg & prev_hot);
                        end
                        if (cnt_reg == CW'(STEP_CYCLES - 1)) begin
                            cnt_reg <= '0;
                            if (step_reg == SW'(N_CLK)) begin
                                state_reg <= RUN;
                                ready_reg <= 1'b1;
                                pend_reg  <= '0;
                                pcnt_reg  <= '0;
                            end else begin
                                step_reg <= step_reg + SW'(1);
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    RUN: begin
                        enclk_reg <= (enclk_reg & ~fall) | rise;
                        pend_reg  <= pend_next;
                        if (|rise) begin
                            pcnt_reg    <= '0;
                            rst_out_reg <= rst_out_reg | fall;
                        end else if ((|pend_next) && (pcnt_reg == CW'(STEP_CYCLES - 2))) begin
                            rst_out_reg <= (rst_out_reg | fall) & ~pend_next;
                            pend_reg    <= '0;
                        end else begin
                            rst_out_reg <= rst_out_reg | fall;
                            if (|pend_next) begin
                                pcnt_reg <= pcnt_reg + CW'(1);
                            end
                        end
                    end
                    FAULT: begin
                        state_reg <= FAULT;
                    end
                    default: begin
                        state_reg <= RESET_PLL;
                    end
                endcase
            end
        end
    end

    assign pll_reset = pll_reset_reg;
    assign enclk     = enclk_reg;
    assign rst_out   = rst_out_reg;
    assign ready     = ready_reg;
    assign fault     = fault_reg;
    assign retry_cnt = retry_reg;
endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Scoreboard bench for pll_clk_sequencer: every output change is matched against a queued
// expectation holding the exact cycle and the full output vector.
module tb_pll_clk_sequencer;
    localparam int N    = 5;
    localparam int PWD  = 4;
    localparam int TO   = 32;
    localparam int LSC  = 8;
    localparam int STEP = 4;
    localparam int RET  = 2;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         pll_lock = 1'b0;
    logic [N-1:0] req_en   = '0;
    logic         pll_reset;
    logic [N-1:0] enclk;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         fault;
    logic [1:0]   retry_cnt;

    typedef struct packed {
        logic         pr;
        logic [N-1:0] en;
        logic [N-1:0] ro;
        logic         rdy;
        logic         flt;
        logic [1:0]   rc;
    } outs_t;

    typedef struct packed {
        int    cyc;
        outs_t o;
    } exp_t;

    exp_t  sb[$];
    outs_t e      = '0;
    outs_t last_e = 'x;
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;
    logic  done   = 1'b0;

    pll_clk_sequencer #(
        .N_CLK(N), .PWD_CYCLES(PWD), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(LSC),
        .STEP_CYCLES(STEP), .RELOCK_RETRIES(RET)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .req_en(req_en),
        .pll_reset(pll_reset), .enclk(enclk), .rst_out(rst_out),
        .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Queue the current expected vector at edge c, only when it differs from the last one.
    task automatic push(input int c);
        exp_t x;
        if (e !== last_e) begin
            x.cyc = c;
            x.o   = e;
            sb.push_back(x);
            last_e = e;
        end
    endtask

    task automatic set_reset(input int c);
        e.pr = 1'b1; e.en = '0; e.ro = '1; e.rdy = 1'b0; e.flt = 1'b0; e.rc = 2'd0;
        push(c);
    endtask

    // SEQ_UP entered at edge s: channel k gated at s+1+STEP*k, its reset released one step later.
    task automatic seq_up(input int s, input logic [N-1:0] req);
        for (int k = 0; k <= N; k++) begin
            if (k < N) e.en[k] = req[k];
            if (k >= 1) e.ro[k-1] = ~req[k-1];
            push(s + 1 + STEP * k);
        end
        e.rdy = 1'b1;
        push(s + STEP * (N + 1));
    endtask

    // Bring-up with lock already qualified: rst released after edge c0.
    task automatic nominal(input int c0, input logic [N-1:0] req);
        e.pr = 1'b0;
        push(c0 + PWD);
        seq_up(c0 + PWD + 1 + LSC, req);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Nominal bring-up with every channel requested.
        set_reset(1);
        nominal(3, 5'b11111);
        wait_cyc(3);
        rst = 1'b0; pll_lock = 1'b1; req_en = 5'b11111;
        wait_cyc(45);

        // Lock glitch in STABLE after 5 good cycles, masked channels.
        set_reset(46);
        e.pr = 1'b0; push(52);
        seq_up(72, 5'b10101);
        rst = 1'b1; pll_lock = 1'b0; req_en = 5'b10101;
        wait_cyc(48); rst = 1'b0;
        wait_cyc(54); pll_lock = 1'b1;
        wait_cyc(60); pll_lock = 1'b0;
        wait_cyc(61); pll_lock = 1'b1;
        wait_cyc(100);

        // Hot add of channels 1 and 3, then hot remove of channel 0.
        e.en = 5'b10111; push(101);
        e.en = 5'b11111; push(103);
        e.ro = 5'b00000; push(106);
        e.en = 5'b11110; e.ro = 5'b00001; push(111);
        req_en = 5'b10111;
        wait_cyc(102); req_en = 5'b11111;
        wait_cyc(110); req_en = 5'b11110;
        wait_cyc(115);

        // Lock loss in RUN, then relock and full re-sequence.
        e.en = '0; e.ro = '1; e.rdy = 1'b0; e.rc = 2'd1; e.pr = 1'b1; push(118);
        e.pr = 1'b0; push(122);
        seq_up(131, 5'b11110);
        pll_lock = 1'b0;
        wait_cyc(118); pll_lock = 1'b1;
        wait_cyc(160);

        // Retry exhaustion via two WAIT_LOCK timeouts, fault is sticky until rst.
        set_reset(161);
        e.pr = 1'b0; push(167);
        e.pr = 1'b1; e.rc = 2'd1; push(199);
        e.pr = 1'b0; push(203);
        e.pr = 1'b1; e.rc = 2'd2; e.flt = 1'b1; push(235);
        rst = 1'b1; pll_lock = 1'b0;
        wait_cyc(163); rst = 1'b0;
        wait_cyc(240); pll_lock = 1'b1;
        wait_cyc(260);
        set_reset(261);
        nominal(262, 5'b11110);
        rst = 1'b1;
        wait_cyc(262); rst = 1'b0;
        wait_cyc(305);
        done = 1'b1;
    end

    initial begin
        outs_t prev;
        outs_t cur;
        exp_t  x;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = {pll_reset, enclk, rst_out, ready, fault, retry_cnt};
            if (cur !== prev) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    x = sb.pop_front();
                    if (x.cyc != cyc || x.o !== cur) begin
                        n_bad++;
                        $display("FAIL out_change got cyc=%0d outs=%b required cyc=%0d outs=%b",
                                 cyc, cur, x.cyc, x.o);
                    end else begin
                        $display("ok cyc=%0d pr=%b en=%b ro=%b rdy=%b flt=%b rc=%0d",
                                 cyc, cur.pr, cur.en, cur.ro, cur.rdy, cur.flt, cur.rc);
                    end
                end
            end
            prev = cur;
            if (done) begin
                n_cmp++;
                if (sb.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_changes got=%0d still pending required=0 (next cyc=%0d)",
                             sb.size(), sb[0].cyc);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end
endmodule

// File: doc/pll_clk_sequencer.md
Name: pll_clk_sequencer

Overview:
Parametrised start-up and supervision sequencer for the SoC PLL's gated clock outputs (ENCLKn pins). It holds the PLL in reset and then waits for a qualified lock. It then enables up to N_CLK output clocks one at a time and releases a per-domain reset behind each clock. It tears everything down on lock loss, retries relock a bounded number of times, and latches a fault if relock keeps failing. Runs on the free-running PLL reference clock, upstream of all PLL-derived domains.

Parameters:
N_CLK, 5, number of gated PLL outputs sequenced (1..7)
PWD_CYCLES, 64, cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before the attempt fails
LOCK_STABLE_CYCLES, 1024, cycles synced lock must stay high continuously before sequencing
STEP_CYCLES, 16, spacing between channel enables; reset-release delay after each enable (>=2)
RELOCK_RETRIES, 3, failed attempts (timeout or lock loss) tolerated before FAULT (>=1)

Ports:
clk  in  1  PLL reference clock; only clock of the block
rst  in  1  synchronous active-high reset
pll_lock  in  1  PLL LOCK, asynchronous; 2-flop synchroniser inside
req_en  in  N_CLK  requested enable mask per output, static or quasi-static
pll_reset  out  1  drives PLL RESET
enclk  out  N_CLK  drives PLL ENCLK0..N_CLK-1
rst_out  out  N_CLK  per-domain synchronous reset, active-high
ready  out  1  high only in RUN
fault  out  1  sticky retry-exhausted flag
retry_cnt  out  clog2(RELOCK_RETRIES+1)  failed attempts since rst

Behaviour:
- All outputs are registered.
- Reset (rst=1): state RESET_PLL, counters 0, retry_cnt=0. Outputs: pll_reset=1, enclk=0, rst_out=all 1, ready=0, fault=0. rst has priority over everything at any time, including mid-sequence.
- lock_s: pll_lock after 2 flops. All lock references below mean lock_s, which is 2 cycles late.
- RESET_PLL:
  - pll_reset=1 for exactly PWD_CYCLES cycles after entry (or after rst falls), then WAIT_LOCK.
  - The cycle after the last pll_reset=1 cycle has pll_reset=0.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Cycle counter reaching LOCK_TIMEOUT -> attempt failed.
- STABLE:
  - Counts consecutive lock_s=1 cycles. Any lock_s=0 returns to WAIT_LOCK with both counters restarted; this does not count as a failure.
  - Count reaching LOCK_STABLE_CYCLES -> SEQ_UP.
- SEQ_UP: N_CLK+1 steps of STEP_CYCLES cycles each. Each channel consumes a step whether requested or not, so latency is fixed at (N_CLK+1)*STEP_CYCLES.
  - On the first cycle of step k (k<N_CLK): enclk[k] <= req_en[k].
  - On the first cycle of step k (k>=1): rst_out[k-1] <= ~req_en[k-1] as sampled at step k-1.
  - After step N_CLK completes -> RUN.
- RUN: ready=1. Per cycle, for each channel i:
  - req_en[i] falls: enclk[i]=0 and rst_out[i]=1 on the next cycle.
  - req_en[i] rises: enclk[i]=1 on the next cycle, and i joins the pending set. One shared counter, restarted on every new rise, releases rst_out for all pending channels STEP_CYCLES cycles after the latest rise.
  - A channel that falls while pending leaves the pending set.
- Lock loss: lock_s=0 in SEQ_UP or RUN (or during SEQ_UP steps) counts as an attempt failure.
- Attempt failure (WAIT_LOCK timeout or lock loss): on the next cycle:
  - enclk=0, rst_out=all 1, ready=0.
  - retry_cnt increments, saturating.
  - If the new retry_cnt == RELOCK_RETRIES -> FAULT, else -> RESET_PLL.
- FAULT: pll_reset=1, enclk=0, rst_out=all 1, fault=1, ready=0. Only rst exits.
- Simultaneous events:
  - Lock loss in the same cycle as a req_en change or step boundary: lock loss wins.
  - Timeout and lock_s rise in the same cycle: lock wins (go STABLE).
- enclk[i]=1 never coincides with pll_reset=1.
- A channel never has rst_out[i]=0 while enclk[i]=0.

Test Plan:
(Bench parameters: N_CLK=5, PWD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, STEP_CYCLES=4, RELOCK_RETRIES=2.)
1. Nominal bring-up: rst 1->0 at cycle 0, pll_lock=1 from cycle 2, req_en=5'b11111 -> pll_reset high cycles 0-3. enclk[0..4] rise 4 cycles apart. Each rst_out[i] falls exactly 4 cycles after its enclk[i]. ready=1 after 24 SEQ_UP cycles. retry_cnt=0.
2. Lock glitch in STABLE: pll_lock drops for 1 cycle after 5 stable cycles -> return to WAIT_LOCK, stable count restarts, retry_cnt stays 0, then bring-up completes normally.
3. Masked channels: req_en=5'b10101 -> enclk=5'b10101, rst_out=5'b01010 in RUN. SEQ_UP duration still 24 cycles.
4. Hot add/remove in RUN: req_en[1] 0->1 then req_en[3] 0->1 two cycles later -> both enclk high 1 cycle after their rise. rst_out[1] and rst_out[3] fall together 4 cycles after the req_en[3] rise. req_en[0] 1->0 -> enclk[0]=0 and rst_out[0]=1 next cycle.
5. Lock loss in RUN: pll_lock=0 -> 2 sync cycles plus 1 cycle later, enclk=0, rst_out=5'b11111, ready=0, retry_cnt=1, pll_reset=1 for 4 cycles; relock -> full re-sequence.
6. Retry exhaustion: pll_lock held 0 -> retry_cnt=1 after 32 WAIT_LOCK cycles, then 2 -> FAULT with fault=1, pll_reset=1. Applying lock has no effect. Asserting rst clears fault and restarts the sequence.
